counter_down_timer: RTL and testbench
=====================================

Name: counter_down_timer

Overview:
- Loadable down-counting timer; the counting-down counterpart of the team's free-running up counter.
- Software or control logic loads a start value and starts the timer; the block decrements once per clock to zero.
- At zero it raises a one-cycle terminal-count pulse, then either stops (one-shot) or reloads and keeps running (periodic).
- Used as the timeout/interval source alongside the existing up counters in the sequential_logic set.

Parameters:
WIDTH, 8, bit width of count, load_val and the internal reload register

Ports:
clk  input  1  system clock; all state changes on posedge except reset
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
load  input  1  synchronous load strobe; captures load_val
load_val  input  WIDTH  value loaded into count and reload register
start  input  1  begin/restart counting (IDLE or DONE only)
stop  input  1  abort counting, return to IDLE, count frozen
hold  input  1  pause decrement while in RUN
auto_reload  input  1  1 = periodic mode, 0 = one-shot; sampled at terminal cycle
count  output  WIDTH  current counter value (registered)
busy  output  1  1 while state == RUN (including held cycles)
tc  output  1  registered one-cycle pulse on terminal count
done  output  1  1 while state == DONE

Behaviour:
- rst=0 (async, any time): count=0, reload_reg=0, state=IDLE, tc=0, done=0, busy=0. Reset mid-count aborts with no tc.
- States: IDLE, RUN, DONE. busy and done decode state directly.
- Input priority each posedge: load > stop > start > hold/decrement.
- tc defaults to 0 every cycle; it is 1 for exactly one cycle when set below.
- load (any state): count<=load_val, reload_reg<=load_val, state<=IDLE, tc<=0.
- stop (no load): state<=IDLE, count unchanged, no tc.
- IDLE: start & count!=0 -> RUN, no decrement that edge. start & count==0 -> ignored, stay IDLE.
- RUN, start ignored. hold=1: count unchanged, stay RUN. hold=0:
  - count>1: count<=count-1.
  - count==1 & auto_reload & reload_reg!=0: count<=reload_reg, tc<=1, stay RUN. Period = reload_reg cycles.
  - count==1 otherwise: count<=0, tc<=1, state<=DONE.
- DONE: count holds 0. start & reload_reg!=0 -> count<=reload_reg, RUN. start & reload_reg==0 -> ignored.
- Latency: load_val=N, start one cycle after load, no hold -> tc high on the Nth posedge after the start edge.
- No wrap-around: count never decrements below 0. Full WIDTH range is valid; load_val=2^WIDTH-1 counts all the way down.
- load and start in the same cycle: only load takes effect. A separate start is required.

Test Plan:
- Reset: rst=0 mid-RUN with count=5 -> count=0, busy=0, tc=0, done=0 immediately, without waiting for clk.
- One-shot: load 4, start, auto_reload=0 -> count 4,3,2,1,0 on successive edges. tc=1 only in the cycle count=0. done=1 and busy=0 afterwards, count stays 0.
- Periodic: load 3, auto_reload=1, start, run 10 cycles -> count 3,2,1,3,2,1,3... tc pulses every 3 cycles. done never asserts.
- Hold/stop: load 6, start, hold=1 for 3 cycles at count=4 -> count stays 4 and busy=1. Release then stop at count=2 -> IDLE, count=2, no tc. Start again -> resumes 2,1,0 with tc.
- Priority/edges: load and start together -> IDLE, count=load_val. Start with count=0 in IDLE -> ignored. Load 0 then start from DONE -> ignored.
- Width: WIDTH=4, load 15, one-shot -> exactly 15 decrements to 0, single tc, no wrap to 15.

Source files
------------

// File: rtl/counter_down_timer.sv
// rtl/counter_down_timer.sv - loadable down-counting timer with one-shot and periodic modes
module counter_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic [WIDTH-1:0] reload_reg, reload_nx, count_nx;
  logic             tc_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= ZERO;
      reload_reg <= ZERO;
      tc         <= 1'b0;
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      reload_reg <= reload_nx;
      tc         <= tc_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    reload_nx = reload_reg;
    tc_nx     = 1'b0;
    if (load) begin
      count_nx  = load_val;
      reload_nx = load_val;
      state_nx  = IDLE;
    end else if (stop) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // The start edge only arms the timer; the first decrement is on the next edge.
          if (start && count != ZERO) state_nx = RUN;
        end
        RUN: begin
          if (!hold) begin
            if (count > ONE) begin
              count_nx = count - ONE;
            end else if (count == ONE && auto_reload && reload_reg != ZERO) begin
              count_nx = reload_reg;
              tc_nx    = 1'b1;
            end else if (count == ONE) begin
              count_nx = ZERO;
              tc_nx    = 1'b1;
              state_nx = DONE;
            end else begin
              state_nx = DONE;
            end
          end
        end
        DONE: begin
          if (start && reload_reg != ZERO) begin
            count_nx = reload_reg;
            state_nx = RUN;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_counter_down_timer.sv
// tb/tb_counter_down_timer.sv - table-driven bench for counter_down_timer (8-bit and 4-bit instances)
module tb_counter_down_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0, start = 1'b0, stop = 1'b0, hold = 1'b0, auto_reload = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [7:0] count;
  logic       busy, tc, done;
  logic [3:0] count4;
  logic       busy4, tc4, done4;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  counter_down_timer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start), .stop(stop),
    .hold(hold), .auto_reload(auto_reload), .count(count), .busy(busy), .tc(tc), .done(done)
  );

  counter_down_timer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val[3:0]), .start(start), .stop(stop),
    .hold(hold), .auto_reload(auto_reload), .count(count4), .busy(busy4), .tc(tc4), .done(done4)
  );

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       st;
    logic       sp;
    logic       hd;
    logic       ar;
    logic [7:0] e_cnt;
    logic       e_busy;
    logic       e_tc;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ld, logic [7:0] lv, logic st, logic sp, logic hd, logic ar,
                              logic [7:0] c, logic b, logic t, logic d);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.hd = hd; v.ar = ar;
    v.e_cnt = c; v.e_busy = b; v.e_tc = t; v.e_done = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [7:0] lv, input logic st, input logic sp,
                       input logic hd, input logic ar);
    @(negedge clk);
    load = ld; load_val = lv; start = st; stop = sp; hold = hd; auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tc_seen;
    // ld  val   st sp hd ar   cnt busy tc done
    vecs.push_back(mk(1, 8'd4, 0, 0, 0, 0, 8'd4, 0, 0, 0));  // one-shot load 4
    vecs.push_back(mk(0, 8'd0, 1, 0, 0, 0, 8'd4, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd3, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd2, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd1, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 1, 1));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 1));
    vecs.push_back(mk(1, 8'd7, 1, 0, 0, 0, 8'd7, 0, 0, 0));  // load+start: load only
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd7, 0, 0, 0));
    vecs.push_back(mk(1, 8'd0, 0, 0, 0, 0, 8'd0, 0, 0, 0));  // load 0
    vecs.push_back(mk(0, 8'd0, 1, 0, 0, 0, 8'd0, 0, 0, 0));  // start at 0 ignored
    vecs.push_back(mk(1, 8'd3, 0, 0, 0, 1, 8'd3, 0, 0, 0));  // periodic load 3
    vecs.push_back(mk(0, 8'd0, 1, 0, 0, 1, 8'd3, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd2, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd1, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd3, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0, 1, 0, 0, 1, 8'd2, 1, 0, 0));  // start ignored in RUN
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd1, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd3, 1, 1, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 1, 8'd2, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 1, 1, 0, 1, 8'd2, 0, 0, 0));  // stop beats start
    vecs.push_back(mk(1, 8'd6, 0, 0, 0, 0, 8'd6, 0, 0, 0));  // hold/stop load 6
    vecs.push_back(mk(0, 8'd0, 1, 0, 0, 0, 8'd6, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd5, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd4, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd4, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd4, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 1, 0, 8'd4, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd3, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd2, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 1, 0, 0, 8'd2, 0, 0, 0));
    vecs.push_back(mk(0, 8'd0, 1, 0, 0, 0, 8'd2, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd1, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 1, 1));
    vecs.push_back(mk(0, 8'd0, 1, 0, 0, 0, 8'd6, 1, 0, 0));  // restart from DONE
    vecs.push_back(mk(0, 8'd0, 0, 1, 0, 0, 8'd6, 0, 0, 0));
    vecs.push_back(mk(1, 8'd2, 0, 0, 0, 1, 8'd2, 0, 0, 0));  // auto_reload sampled at terminal
    vecs.push_back(mk(0, 8'd0, 1, 0, 0, 1, 8'd2, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd1, 1, 0, 0));
    vecs.push_back(mk(0, 8'd0, 0, 0, 0, 0, 8'd0, 0, 1, 1));

    #12;
    chk("reset_count", count, 8'd0);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_tc", {7'd0, tc}, 8'd0);
    chk("reset_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].hd, vecs[i].ar);
      chk($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
      chk($sformatf("v%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].e_busy});
      chk($sformatf("v%0d_tc", i), {7'd0, tc}, {7'd0, vecs[i].e_tc});
      chk($sformatf("v%0d_done", i), {7'd0, done}, {7'd0, vecs[i].e_done});
    end

    // Asynchronous reset mid-run at count=5, checked well before the next clock edge.
    drive(1, 8'd9, 0, 0, 0, 0);
    drive(0, 8'd0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(0, 8'd0, 0, 0, 0, 0);
    chk("pre_reset_count", count, 8'd5);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", count, 8'd0);
    chk("async_rst_busy", {7'd0, busy}, 8'd0);
    chk("async_rst_tc", {7'd0, tc}, 8'd0);
    chk("async_rst_done", {7'd0, done}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 8'd0, 0, 0, 0, 0);
    chk("post_rst_tc", {7'd0, tc}, 8'd0);
    chk("post_rst_count", count, 8'd0);

    // WIDTH=4 full-range one-shot: 15 decrements, tc on the 15th edge after start, no wrap.
    drive(1, 8'd15, 0, 0, 0, 0);
    drive(0, 8'd0, 1, 0, 0, 0);
    chk("w4_start_count", {4'd0, count4}, 8'd15);
    tc_seen = 0;
    for (int k = 1; k <= 18; k++) begin
      drive(0, 8'd0, 0, 0, 0, 0);
      chk($sformatf("w4_count_e%0d", k), {4'd0, count4}, (k <= 15) ? 8'(15 - k) : 8'd0);
      chk($sformatf("w4_tc_e%0d", k), {7'd0, tc4}, (k == 15) ? 8'd1 : 8'd0);
      if (tc4) tc_seen++;
    end
    chk("w4_tc_total", 8'(tc_seen), 8'd1);
    chk("w4_done", {7'd0, done4}, 8'd1);
    chk("w4_busy", {7'd0, busy4}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
